// File: rtl/digi_logic_sweeper.sv
// Exhaustive 16-vector stimulus driver and response checker for 4-input combinational blocks.
// Define DIGI_SWEEP_MISR_EN to build the 16-bit response MISR behind o_signature.
module digi_logic_sweeper #(
   parameter int unsigned NUM_OUTS      = 2,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_start,
   input  logic                      i_abort,
   input  logic [NUM_OUTS*16-1:0]    i_golden,
   input  logic [NUM_OUTS-1:0]       i_resp,
   output logic [3:0]                o_stim,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_pass,
   output logic [3:0]                o_first_fail,
   output logic [NUM_OUTS*16-1:0]    o_resp_map,
   output logic [15:0]               o_signature
);

   localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

   state_e                        r_state;
   state_e                        w_state_d;
   logic [3:0]                    r_stim;
   logic [3:0]                    w_stim_d;
   logic [CntW-1:0]               r_cnt;
   logic [CntW-1:0]               w_cnt_d;
   logic [NUM_OUTS-1:0][15:0]     r_map;
   logic [NUM_OUTS-1:0][15:0]     w_map_d;
   logic                          r_busy;
   logic                          w_busy_d;
   logic                          r_done;
   logic                          w_done_d;
   logic                          r_pass;
   logic                          w_pass_d;
   logic [3:0]                    r_first_fail;
   logic [3:0]                    w_first_fail_d;
   logic                          r_mismatch;
   logic                          w_mismatch_d;

   logic [NUM_OUTS-1:0][15:0]     w_golden;
   logic [NUM_OUTS-1:0]           w_gold_vec;
   logic                          w_vec_miss;
   logic                          w_start;
   logic                          w_abort;
   logic                          w_sample;

   assign w_golden = i_golden;
   // abort outranks everything once a sweep is under way; in IDLE it also masks start
   assign w_start  = (r_state == StIdle) && i_start && !i_abort;
   assign w_abort  = (r_state != StIdle) && i_abort;
   assign w_sample = (r_state == StSample) && !i_abort;

   always_comb begin
      w_gold_vec = '0;
      for (int k = 0; k < NUM_OUTS; k++) begin
         w_gold_vec[k] = w_golden[k][r_stim];
      end
   end

   assign w_vec_miss = |(w_gold_vec ^ i_resp);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_d = r_state;
      if (w_abort) begin
         w_state_d = StIdle;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_start) begin
                  w_state_d = StSettle;
               end
            end
            StSettle: begin
               if (r_cnt == CntLast) begin
                  w_state_d = StSample;
               end
            end
            StSample: begin
               w_state_d = (r_stim == 4'hF) ? StDone : StSettle;
            end
            StDone: begin
               w_state_d = StIdle;
            end
            default: begin
               w_state_d = StIdle;
            end
         endcase
      end
   end

   // Output and datapath next values
   always_comb begin
      w_stim_d       = r_stim;
      w_cnt_d        = r_cnt;
      w_map_d        = r_map;
      w_busy_d       = r_busy;
      w_done_d       = 1'b0;
      w_pass_d       = r_pass;
      w_first_fail_d = r_first_fail;
      w_mismatch_d   = r_mismatch;
      if (w_start) begin
         w_stim_d       = 4'h0;
         w_cnt_d        = '0;
         w_map_d        = '0;
         w_busy_d       = 1'b1;
         w_pass_d       = 1'b0;
         w_first_fail_d = 4'h0;
         w_mismatch_d   = 1'b0;
      end else if (w_abort) begin
         w_busy_d = 1'b0;
         w_pass_d = 1'b0;
      end else if (w_sample) begin
         for (int k = 0; k < NUM_OUTS; k++) begin
            w_map_d[k][r_stim] = i_resp[k];
         end
         if (w_vec_miss && !r_mismatch) begin
            w_first_fail_d = r_stim;
            w_mismatch_d   = 1'b1;
         end
         if (r_stim == 4'hF) begin
            w_busy_d = 1'b0;
            w_done_d = 1'b1;
            w_pass_d = !(r_mismatch || w_vec_miss);
         end else begin
            w_stim_d = r_stim + 4'h1;
            w_cnt_d  = '0;
         end
      end else if ((r_state == StSettle) && (r_cnt != CntLast)) begin
         w_cnt_d = r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stim       <= 4'h0;
         r_cnt        <= '0;
         r_map        <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_first_fail <= 4'h0;
         r_mismatch   <= 1'b0;
      end else begin
         r_stim       <= w_stim_d;
         r_cnt        <= w_cnt_d;
         r_map        <= w_map_d;
         r_busy       <= w_busy_d;
         r_done       <= w_done_d;
         r_pass       <= w_pass_d;
         r_first_fail <= w_first_fail_d;
         r_mismatch   <= w_mismatch_d;
      end
   end

`ifdef DIGI_SWEEP_MISR_EN
   logic [15:0] r_sig;
   logic [15:0] w_sig_d;
   logic        w_fb;

   assign w_fb = r_sig[15] ^ r_sig[13] ^ r_sig[12] ^ r_sig[10];

   always_comb begin
      w_sig_d = r_sig;
      if (w_start) begin
         w_sig_d = 16'hFFFF;
      end else if (w_sample) begin
         w_sig_d = {r_sig[14:0], w_fb} ^ 16'(i_resp);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sig <= 16'hFFFF;
      end else begin
         r_sig <= w_sig_d;
      end
   end

   assign o_signature = r_sig;
`else
   assign o_signature = 16'h0000;
`endif

   assign o_stim       = r_stim;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_pass       = r_pass;
   assign o_first_fail = r_first_fail;
   assign o_resp_map   = r_map;

endmodule

// File: tb/tb_digi_logic_sweeper.sv
// Randomised self-checking bench for digi_logic_sweeper; two instances (SETTLE_CYCLES 1 and 3).
// Expected maps, verdicts and MISR signatures come from a truth-table model kept in the bench.
module tb_digi_logic_sweeper;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start1, abort1, start3, abort3;
   logic [31:0] golden1, golden3, tt1, tt3;
   logic [15:0] tt1_lo, tt1_hi, tt3_lo, tt3_hi;
   logic [1:0]  resp1, resp3;
   logic [3:0]  stim1, stim3, ff1, ff3;
   logic        busy1, busy3, done1, done3, pass1, pass3;
   logic [31:0] map1, map3;
   logic [15:0] sig1, sig3;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef DIGI_SWEEP_MISR_EN
   localparam logic [15:0] SigReset = 16'hFFFF;
`else
   localparam logic [15:0] SigReset = 16'h0000;
`endif

   always #5 clk = ~clk;

   // Block under test modelled as a truth table: bit k*16+v = output k at input vector v
   always_comb begin
      tt1_lo = tt1[15:0];
      tt1_hi = tt1[31:16];
      tt3_lo = tt3[15:0];
      tt3_hi = tt3[31:16];
      resp1  = {tt1_hi[stim1], tt1_lo[stim1]};
      resp3  = {tt3_hi[stim3], tt3_lo[stim3]};
   end

   digi_logic_sweeper #(.NUM_OUTS(2), .SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .i_start(start1), .i_abort(abort1), .i_golden(golden1),
      .i_resp(resp1), .o_stim(stim1), .o_busy(busy1), .o_done(done1), .o_pass(pass1),
      .o_first_fail(ff1), .o_resp_map(map1), .o_signature(sig1)
   );

   digi_logic_sweeper #(.NUM_OUTS(2), .SETTLE_CYCLES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .i_start(start3), .i_abort(abort3), .i_golden(golden3),
      .i_resp(resp3), .o_stim(stim3), .o_busy(busy3), .o_done(done3), .o_pass(pass3),
      .o_first_fail(ff3), .o_resp_map(map3), .o_signature(sig3)
   );

   function automatic logic [31:0] formula_map();
      logic [31:0] m;
      logic [3:0]  s;
      logic        a, b, c, d;
      m = '0;
      for (int v = 0; v < 16; v++) begin
         s = 4'(v);
         a = s[3]; b = s[2]; c = s[1]; d = s[0];
         m[v]      = a | (c & ~b) | ((b & ~a) ^ d);
         m[16 + v] = ~(d | (b & ~a));
      end
      return m;
   endfunction

   function automatic logic [3:0] ref_first_fail(input logic [31:0] m, input logic [31:0] g);
      for (int v = 0; v < 16; v++) begin
         if ((m[v] != g[v]) || (m[16 + v] != g[16 + v])) return 4'(v);
      end
      return 4'h0;
   endfunction

   function automatic logic [15:0] exp_sig(input logic [31:0] m);
`ifdef DIGI_SWEEP_MISR_EN
      logic [15:0] s;
      logic        fb;
      s = 16'hFFFF;
      for (int v = 0; v < 16; v++) begin
         fb = s[15] ^ s[13] ^ s[12] ^ s[10];
         s  = {s[14:0], fb} ^ {14'd0, m[16 + v], m[v]};
      end
      return s;
`else
      return 16'h0000 & m[15:0];
`endif
   endfunction

   // Pulses start on dut1 and follows the sweep until one cycle past done (bounded)
   task automatic run1(output int k_done, output int n_done, output logic b_first,
                       output logic [3:0] s_first, output logic [15:0] sig_first);
      start1 = 1'b1;
      @(negedge clk);
      start1    = 1'b0;
      k_done    = -1;
      n_done    = 0;
      b_first   = busy1;
      s_first   = stim1;
      sig_first = sig1;
      for (int k = 1; k <= 200; k++) begin
         if (k > 1) @(negedge clk);
         if (done1) begin
            n_done++;
            if (k_done < 0) k_done = k;
         end
         if ((k_done >= 0) && (k == k_done + 1)) break;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
      golden1 = '0; golden3 = '0; tt1 = '0; tt3 = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({stim1, busy1, done1, pass1, ff1} !== 11'h0)
         $display("FAIL reset_ctrl1: got %h want 0", {stim1, busy1, done1, pass1, ff1});
      else n_pass++;
      n_checks++;
      if ({map1, sig1} !== {32'h0, SigReset})
         $display("FAIL reset_map_sig1: got %h want %h", {map1, sig1}, {32'h0, SigReset});
      else n_pass++;
      n_checks++;
      if ({stim3, busy3, done3, pass3, ff3, map3, sig3} !== {11'h0, 32'h0, SigReset})
         $display("FAIL reset_dut3: got %h", {stim3, busy3, done3, pass3, ff3, map3, sig3});
      else n_pass++;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy1 !== 1'b0) $display("FAIL reset_idle: busy %b want 0", busy1);
      else n_pass++;
   endtask

   task automatic test_golden_sweep();
      int k_done, n_done;
      logic b0;
      logic [3:0] s0;
      logic [15:0] g0;
      tt1 = formula_map();
      golden1 = 32'h5505_FF5E;
      run1(k_done, n_done, b0, s0, g0);
      n_checks++;
      if ({b0, s0, g0} !== {1'b1, 4'h0, SigReset})
         $display("FAIL golden_after_start: got %h want %h", {b0, s0, g0}, {1'b1, 4'h0, SigReset});
      else n_pass++;
      n_checks++;
      if ((k_done !== 33) || (n_done !== 1))
         $display("FAIL golden_done_cycle: got k=%0d n=%0d want k=33 n=1", k_done, n_done);
      else n_pass++;
      n_checks++;
      if ({pass1, ff1, busy1, stim1} !== {1'b1, 4'h0, 1'b0, 4'hF})
         $display("FAIL golden_verdict: got %h want %h", {pass1, ff1, busy1, stim1},
                  {1'b1, 4'h0, 1'b0, 4'hF});
      else n_pass++;
      n_checks++;
      if (map1 !== 32'h5505_FF5E) $display("FAIL golden_map: got %h want 5505ff5e", map1);
      else n_pass++;
      n_checks++;
      if (sig1 !== exp_sig(32'h5505_FF5E))
         $display("FAIL golden_sig: got %h want %h", sig1, exp_sig(32'h5505_FF5E));
      else n_pass++;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({stim1, pass1} !== {4'hF, 1'b1})
         $display("FAIL golden_hold: got stim %h pass %b want f 1", stim1, pass1);
      else n_pass++;
   endtask

   task automatic test_fault();
      int k_done, n_done;
      logic b0;
      logic [3:0] s0;
      logic [15:0] g0;
      tt1 = formula_map() | 32'h0000_0020;
      golden1 = 32'h5505_FF5E;
      run1(k_done, n_done, b0, s0, g0);
      n_checks++;
      if ({pass1, ff1, map1[5]} !== {1'b0, 4'h5, 1'b1})
         $display("FAIL fault_verdict: got pass %b ff %0d map5 %b want 0 5 1", pass1, ff1, map1[5]);
      else n_pass++;
      n_checks++;
      if ((map1 !== tt1) || (k_done !== 33))
         $display("FAIL fault_map: got %h k=%0d want %h k=33", map1, k_done, tt1);
      else n_pass++;
   endtask

   task automatic test_random();
      int k_done, n_done;
      logic b0;
      logic [3:0] s0;
      logic [15:0] g0;
      int mode;
      for (int it = 0; it < 10; it++) begin
         tt1  = $urandom;
         mode = int'($urandom_range(0, 2));
         if (mode == 0) golden1 = tt1;
         else if (mode == 1) golden1 = tt1 ^ (32'h1 << $urandom_range(0, 31));
         else golden1 = tt1 ^ $urandom;
         run1(k_done, n_done, b0, s0, g0);
         n_checks++;
         if ((map1 !== tt1) || (k_done !== 33) || (n_done !== 1))
            $display("FAIL rand_map[%0d]: got %h k=%0d n=%0d want %h k=33 n=1", it, map1, k_done,
                     n_done, tt1);
         else n_pass++;
         n_checks++;
         if ({pass1, ff1} !== {(golden1 == tt1), ref_first_fail(tt1, golden1)})
            $display("FAIL rand_verdict[%0d]: got pass %b ff %0d want %b %0d", it, pass1, ff1,
                     (golden1 == tt1), ref_first_fail(tt1, golden1));
         else n_pass++;
         n_checks++;
         if (sig1 !== exp_sig(tt1))
            $display("FAIL rand_sig[%0d]: got %h want %h", it, sig1, exp_sig(tt1));
         else n_pass++;
      end
   endtask

   task automatic test_settle3();
      int cnt[16];
      int k_done;
      logic [3:0] s_done;
      for (int v = 0; v < 16; v++) cnt[v] = 0;
      tt3 = $urandom;
      golden3 = tt3;
      k_done = -1;
      s_done = 4'h0;
      start3 = 1'b1;
      @(negedge clk);
      for (int k = 1; k <= 200; k++) begin
         if (k > 1) @(negedge clk);
         start3 = ((k == 10) || (k == 30) || (k == 50)) ? 1'b1 : 1'b0;
         if (busy3) cnt[stim3]++;
         if (done3) begin
            k_done = k;
            s_done = stim3;
            break;
         end
      end
      start3 = 1'b0;
      for (int v = 0; v < 16; v++) begin
         n_checks++;
         if (cnt[v] !== 4) $display("FAIL settle3_cycles[%0d]: got %0d want 4", v, cnt[v]);
         else n_pass++;
      end
      n_checks++;
      if ((k_done !== 65) || (s_done !== 4'hF))
         $display("FAIL settle3_done: got k=%0d stim=%0d want 65 15", k_done, s_done);
      else n_pass++;
      n_checks++;
      if ({pass3, ff3, map3, sig3} !== {1'b1, 4'h0, tt3, exp_sig(tt3)})
         $display("FAIL settle3_result: got %h want %h", {pass3, ff3, map3, sig3},
                  {1'b1, 4'h0, tt3, exp_sig(tt3)});
      else n_pass++;
      repeat (5) @(negedge clk);
      n_checks++;
      if (busy3 !== 1'b0) $display("FAIL settle3_no_restart: busy %b want 0", busy3);
      else n_pass++;
   endtask

   task automatic test_abort();
      int n_done;
      bit found;
      tt1 = $urandom;
      golden1 = tt1;
      found = 1'b0;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (stim1 == 4'h7) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      n_checks++;
      if (!found) $display("FAIL abort_reach7: stim stuck at %0d want 7", stim1);
      else n_pass++;
      abort1 = 1'b1;
      @(negedge clk);
      abort1 = 1'b0;
      n_checks++;
      if ({busy1, done1, pass1} !== 3'b000)
         $display("FAIL abort_state: got busy/done/pass %b want 000", {busy1, done1, pass1});
      else n_pass++;
      n_checks++;
      if (map1 !== (tt1 & 32'h007F_007F))
         $display("FAIL abort_partial_map: got %h want %h", map1, tt1 & 32'h007F_007F);
      else n_pass++;
      n_done = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done1 || busy1) n_done++;
      end
      n_checks++;
      if (n_done !== 0) $display("FAIL abort_no_done: got %0d active cycles want 0", n_done);
      else n_pass++;
   endtask

   task automatic test_start_abort_idle();
      int k_done, n_done;
      logic b0;
      logic [3:0] s0;
      logic [15:0] g0;
      tt1 = $urandom;
      golden1 = tt1;
      run1(k_done, n_done, b0, s0, g0);
      n_checks++;
      if (pass1 !== 1'b1) $display("FAIL idle_setup_pass: got %b want 1", pass1);
      else n_pass++;
      start1 = 1'b1;
      abort1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      abort1 = 1'b0;
      n_checks++;
      if ({busy1, stim1, pass1} !== {1'b0, 4'hF, 1'b1})
         $display("FAIL idle_start_abort: got busy %b stim %0d pass %b want 0 15 1", busy1, stim1,
                  pass1);
      else n_pass++;
      n_done = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done1 || busy1) n_done++;
      end
      n_checks++;
      if (n_done !== 0) $display("FAIL idle_no_sweep: got %0d active cycles want 0", n_done);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int n_done;
      tt1 = $urandom;
      golden1 = tt1;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (stim1 == 4'hA) break;
         @(negedge clk);
      end
      n_checks++;
      if (stim1 !== 4'hA) $display("FAIL rstmid_reach10: got %0d want 10", stim1);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({stim1, busy1, done1, pass1, ff1, map1, sig1} !== {11'h0, 32'h0, SigReset})
         $display("FAIL rstmid_values: got %h want %h", {stim1, busy1, done1, pass1, ff1, map1,
                  sig1}, {11'h0, 32'h0, SigReset});
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done1 || busy1) n_done++;
      end
      n_checks++;
      if (n_done !== 0) $display("FAIL rstmid_no_done: got %0d active cycles want 0", n_done);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int k_done, k2;
      bit seen;
      tt1 = $urandom;
      golden1 = tt1 ^ 32'h0001_0000;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      seen = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         if (k > 1) @(negedge clk);
         if (done1) begin
            seen = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!seen) $display("FAIL b2b_first_done: done never seen want pulse");
      else n_pass++;
      // start held through DONE (ignored) and into IDLE (accepted)
      start1 = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy1, done1} !== 2'b00)
         $display("FAIL b2b_in_done: got busy/done %b want 00", {busy1, done1});
      else n_pass++;
      @(negedge clk);
      start1 = 1'b0;
      n_checks++;
      if ({busy1, stim1, pass1} !== {1'b1, 4'h0, 1'b0})
         $display("FAIL b2b_accept: got busy %b stim %0d pass %b want 1 0 0", busy1, stim1, pass1);
      else n_pass++;
      tt1 = $urandom;
      golden1 = tt1;
      k2 = -1;
      for (int k = 2; k <= 100; k++) begin
         @(negedge clk);
         if (done1) begin
            k2 = k;
            break;
         end
      end
      k_done = k2;
      n_checks++;
      if ((k_done !== 33) || ({pass1, ff1, map1} !== {1'b1, 4'h0, tt1}))
         $display("FAIL b2b_second: got k=%0d pass %b ff %0d map %h want 33 1 0 %h", k_done, pass1,
                  ff1, map1, tt1);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_golden_sweep();
      test_fault();
      test_random();
      test_settle3();
      test_abort();
      test_start_abort_idle();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
      $fatal(1);
   end

endmodule
